// File: rtl/alu_decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU decode stage and its consumers.
//   - alu_sel_e : 5-bit ALU operation code (encoding is fixed, add = 0).
//   - OPC_*     : RV32I major opcodes handled by the decode stage.
//   - F7_*      : funct7 values that distinguish base / alternate ops.
//   - alu_ctl_t : decoded-op control fields (sel, rd, rd_we, illegal).
//                 The operands (in1/in2) are WIDTH-parameterized and are
//                 appended to this struct inside the stage, because a
//                 package cannot carry a module parameter.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_SLL   = 5'd2,
        ALU_SRL   = 5'd3,
        ALU_SRA   = 5'd4,
        ALU_AND   = 5'd5,
        ALU_OR    = 5'd6,
        ALU_XOR   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_ADDI  = 5'd10,
        ALU_SLLI  = 5'd11,
        ALU_SRLI  = 5'd12,
        ALU_SRAI  = 5'd13,
        ALU_ANDI  = 5'd14,
        ALU_ORI   = 5'd15,
        ALU_XORI  = 5'd16,
        ALU_SLTI  = 5'd17,
        ALU_SLTIU = 5'd18,
        ALU_LUI   = 5'd19,
        ALU_AUIPC = 5'd20
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        alu_sel_e   sel;
        logic [4:0] rd;
        logic       rd_we;
        logic       illegal;
    } alu_ctl_t;

endpackage

// File: rtl/alu_decode_stage_scoreboard.sv
// ---------------------------------------------------------------------------
// alu_scoreboard
//   Tracks which architectural registers have an issued but not yet retired
//   writer, and flags a hazard when the instruction being offered reads one.
//   x0 is never pending. A set and a clear of the same register in the same
//   cycle leave it pending (the new writer is younger than the retiring one).
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset (clears all bits)
//   i_set         : mark i_set_rd pending (accepted op that writes back)
//   i_clr         : retire strobe for i_clr_rd
//   i_rs1/i_rs2   : source registers of the offered instruction
//   i_rs*_used    : source actually read by the offered instruction
//   o_hazard      : a used source is pending (registered state only)
// ---------------------------------------------------------------------------
module alu_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_set,
    input  logic [4:0] i_set_rd,
    input  logic       i_clr,
    input  logic [4:0] i_clr_rd,
    input  logic [4:0] i_rs1,
    input  logic       i_rs1_used,
    input  logic [4:0] i_rs2,
    input  logic       i_rs2_used,
    output logic       o_hazard
);

    logic [31:1] r_pending;
    logic [31:0] w_pend_full;

    // Bit 0 is tied low so x0 sources never stall and indexing stays in range.
    assign w_pend_full = {r_pending, 1'b0};

    // No same-cycle retire bypass: a stalled reader issues the cycle after
    // its producer's retire strobe.
    assign o_hazard = (i_rs1_used && w_pend_full[i_rs1]) ||
                      (i_rs2_used && w_pend_full[i_rs2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (i_set && i_set_rd == 5'(i))
                    r_pending[i] <= 1'b1;
                else if (i_clr && i_clr_rd == 5'(i))
                    r_pending[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//   Decodes one RV32I integer instruction (OP, OP-IMM, LUI, AUIPC) per
//   handshake into an ALU operation plus operands, registered with one cycle
//   of latency, and feeds the combinational ALU in the execute stage.
//   Register read-after-write hazards are held off by alu_scoreboard.
//
// Build option
//   ALU_DECODE_SKID_EN : adds a second output entry. in_ready then depends
//                        only on the skid entry and the hazard, never on
//                        out_ready. Undefined: single output register.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : instruction handshake
//   instr, pc             : instruction word and its address
//   rs1_addr, rs2_addr    : register-file read addresses (combinational)
//   rs1_data, rs2_data    : register-file read data (same cycle)
//   out_valid / out_ready : decoded-op handshake
//   alu_sel, alu_in1/2    : ALU operation and operands
//   rd, rd_we             : destination register and writeback enable
//   illegal               : instruction not decodable (passes through)
//   wb_valid, wb_rd       : retire strobe clearing the scoreboard
// ---------------------------------------------------------------------------
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       alu_sel,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [4:0]       rd,
    output logic             rd_we,
    output logic             illegal,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd
);

    if (WIDTH < 32) begin : g_width_chk
        $error("alu_decode_stage: WIDTH must be >= 32");
    end

    typedef struct packed {
        alu_ctl_t         ctl;
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
    } dec_op_t;

    // ---------------- instruction fields ----------------
    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [6:0]       w_funct7;
    logic [4:0]       w_rd;
    logic [WIDTH-1:0] w_imm_i;
    logic [WIDTH-1:0] w_imm_u;
    logic [WIDTH-1:0] w_shamt;

    assign w_opcode = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign w_imm_i  = WIDTH'($signed(instr[31:20]));
    assign w_imm_u  = WIDTH'($signed({instr[31:12], 12'b0}));
    assign w_shamt  = WIDTH'(instr[24:20]);

    // ---------------- decode ----------------
    logic             w_ok;
    alu_sel_e         w_sel;
    logic [WIDTH-1:0] w_in1;
    logic [WIDTH-1:0] w_in2;
    logic             w_rs1_used;
    logic             w_rs2_used;
    dec_op_t          w_op;

    always_comb begin
        w_ok       = 1'b0;
        w_sel      = ALU_ADD;
        w_in1      = '0;
        w_in2      = '0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_ok       = 1'b1;
                w_in1      = rs1_data;
                w_in2      = rs2_data;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                case ({w_funct7, w_funct3})
                    {F7_BASE, 3'b000}: w_sel = ALU_ADD;
                    {F7_ALT,  3'b000}: w_sel = ALU_SUB;
                    {F7_BASE, 3'b001}: w_sel = ALU_SLL;
                    {F7_BASE, 3'b010}: w_sel = ALU_SLT;
                    {F7_BASE, 3'b011}: w_sel = ALU_SLTU;
                    {F7_BASE, 3'b100}: w_sel = ALU_XOR;
                    {F7_BASE, 3'b101}: w_sel = ALU_SRL;
                    {F7_ALT,  3'b101}: w_sel = ALU_SRA;
                    {F7_BASE, 3'b110}: w_sel = ALU_OR;
                    {F7_BASE, 3'b111}: w_sel = ALU_AND;
                    default:           w_ok  = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                w_ok       = 1'b1;
                w_in1      = rs1_data;
                w_in2      = w_imm_i;
                w_rs1_used = 1'b1;
                case (w_funct3)
                    3'b000: w_sel = ALU_ADDI;
                    3'b010: w_sel = ALU_SLTI;
                    3'b011: w_sel = ALU_SLTIU;
                    3'b100: w_sel = ALU_XORI;
                    3'b110: w_sel = ALU_ORI;
                    3'b111: w_sel = ALU_ANDI;
                    3'b001: begin
                        w_sel = ALU_SLLI;
                        w_in2 = w_shamt;
                        w_ok  = (w_funct7 == F7_BASE);
                    end
                    default: begin // 3'b101: srli / srai
                        w_in2 = w_shamt;
                        if (w_funct7 == F7_BASE)     w_sel = ALU_SRLI;
                        else if (w_funct7 == F7_ALT) w_sel = ALU_SRAI;
                        else                         w_ok  = 1'b0;
                    end
                endcase
            end
            OPC_LUI: begin
                w_ok  = 1'b1;
                w_sel = ALU_LUI;
                w_in2 = w_imm_u;
            end
            OPC_AUIPC: begin
                w_ok  = 1'b1;
                w_sel = ALU_AUIPC;
                w_in1 = pc;
                w_in2 = w_imm_u;
            end
            default: w_ok = 1'b0;
        endcase

        // Undecodable ops carry no operands and read no registers, so they
        // never stall and never mark a destination pending.
        if (!w_ok) begin
            w_sel      = ALU_ADD;
            w_in1      = '0;
            w_in2      = '0;
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
        end

        w_op.ctl.sel     = w_sel;
        w_op.ctl.rd      = w_rd;
        w_op.ctl.rd_we   = w_ok && (w_rd != 5'd0);
        w_op.ctl.illegal = !w_ok;
        w_op.in1         = w_in1;
        w_op.in2         = w_in2;
    end

    // ---------------- scoreboard ----------------
    logic w_hazard;
    logic w_accept;

    assign w_accept = in_valid && in_ready;

    alu_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set      (w_accept && w_op.ctl.rd_we),
        .i_set_rd   (w_rd),
        .i_clr      (wb_valid),
        .i_clr_rd   (wb_rd),
        .i_rs1      (rs1_addr),
        .i_rs1_used (w_rs1_used),
        .i_rs2      (rs2_addr),
        .i_rs2_used (w_rs2_used),
        .o_hazard   (w_hazard)
    );

    // ---------------- output register(s) ----------------
    dec_op_t r_out;
    logic    r_out_vld;

`ifdef ALU_DECODE_SKID_EN
    dec_op_t r_skid;
    logic    r_skid_vld;
    logic    w_pop;

    assign w_pop    = r_out_vld && out_ready;
    assign in_ready = !r_skid_vld && !w_hazard;

    // Accept only happens with the skid entry empty, so a skid-held op is
    // always older than anything arriving and drains into r_out first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
        end else if (w_accept && (!r_out_vld || w_pop)) begin
            r_out     <= w_op;
            r_out_vld <= 1'b1;
        end else if (w_accept) begin
            r_skid     <= w_op;
            r_skid_vld <= 1'b1;
        end else if (w_pop) begin
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end
    end
`else
    assign in_ready = (!r_out_vld || out_ready) && !w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (w_accept) begin
            r_out     <= w_op;
            r_out_vld <= 1'b1;
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end
`endif

    assign out_valid = r_out_vld;
    assign alu_sel   = r_out.ctl.sel;
    assign alu_in1   = r_out.in1;
    assign alu_in2   = r_out.in2;
    assign rd        = r_out.ctl.rd;
    assign rd_we     = r_out.ctl.rd_we;
    assign illegal   = r_out.ctl.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;

`ifdef ALU_DECODE_SKID_EN
    localparam int EXP_STALL_ACC = 2;
`else
    localparam int EXP_STALL_ACC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        in_ready, out_valid, rd_we, illegal;
    logic [4:0]  rs1_addr, rs2_addr, alu_sel, rd;
    logic [31:0] alu_in1, alu_in2, rs1_data, rs2_data;
    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always #5 clk = ~clk;

    alu_decode_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_sel(alu_sel), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .rd(rd), .rd_we(rd_we), .illegal(illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    // Offer an instruction from a negedge, wait (bounded) for in_ready, let it
    // be accepted, return at the following negedge with the op on the outputs.
    task automatic issue(input logic [31:0] ins, input logic [31:0] p, output int waits);
        waits = 0;
        instr = ins; pc = p; in_valid = 1'b1;
        #1;
        while (!in_ready && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout instr=%h in_ready stayed 0", ins);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic retire(input logic [4:0] r);
        wb_valid = 1'b1; wb_rd = r;
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d exp 0", out_valid); end
        checks++; if (alu_sel !== 5'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", alu_sel); end
        checks++; if (alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin errors++; $display("FAIL rst_in got %h/%h exp 0/0", alu_in1, alu_in2); end
        checks++; if (rd !== 5'd0 || rd_we !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rst_ctl got rd=%0d we=%0d ill=%0d exp 0/0/0", rd, rd_we, illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_op();
        int w;
        instr = 32'h002081B3; #1;
        checks++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin errors++; $display("FAIL rs_addr got %0d/%0d exp 1/2", rs1_addr, rs2_addr); end
        issue(32'h002081B3, 32'h0, w); // add x3,x1,x2
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0d exp 1", out_valid); end
        checks++; if (alu_sel !== 5'd0 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin errors++; $display("FAIL add_op got sel=%0d in1=%0d in2=%0d exp 0/5/7", alu_sel, alu_in1, alu_in2); end
        checks++; if (rd !== 5'd3 || rd_we !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL add_ctl got rd=%0d we=%0d ill=%0d exp 3/1/0", rd, rd_we, illegal); end
        retire(5'd3);
        issue(32'h40208533, 32'h0, w); // sub x10,x1,x2
        checks++; if (alu_sel !== 5'd1 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || rd !== 5'd10) begin errors++; $display("FAIL sub_op got sel=%0d in1=%0d in2=%0d rd=%0d exp 1/5/7/10", alu_sel, alu_in1, alu_in2, rd); end
        retire(5'd10);
        issue(32'h022081B3, 32'h0, w); // funct7=0000001 is not RV32I
        checks++; if (illegal !== 1'b1 || rd_we !== 1'b0 || alu_sel !== 5'd0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin errors++; $display("FAIL op_f7_illegal got ill=%0d we=%0d sel=%0d in1=%h in2=%h exp 1/0/0/0/0", illegal, rd_we, alu_sel, alu_in1, alu_in2); end
    endtask

    task automatic test_op_imm();
        int w;
        issue(32'hFFF00213, 32'h0, w); // addi x4,x0,-1
        checks++; if (alu_sel !== 5'd10 || alu_in1 !== 32'h0 || alu_in2 !== 32'hFFFFFFFF || rd !== 5'd4 || rd_we !== 1'b1) begin errors++; $display("FAIL addi_op got sel=%0d in1=%h in2=%h rd=%0d we=%0d exp 10/0/ffffffff/4/1", alu_sel, alu_in1, alu_in2, rd, rd_we); end
        retire(5'd4);
        issue(32'h4032D293, 32'h0, w); // srai x5,x5,3
        checks++; if (alu_sel !== 5'd13 || alu_in1 !== 32'd40 || alu_in2 !== 32'd3 || rd !== 5'd5) begin errors++; $display("FAIL srai_op got sel=%0d in1=%0d in2=%0d rd=%0d exp 13/40/3/5", alu_sel, alu_in1, alu_in2, rd); end
        retire(5'd5);
        issue(32'h40329293, 32'h0, w); // slli with funct7=0100000
        checks++; if (illegal !== 1'b1 || rd_we !== 1'b0 || alu_in2 !== 32'h0) begin errors++; $display("FAIL slli_f7_illegal got ill=%0d we=%0d in2=%h exp 1/0/0", illegal, rd_we, alu_in2); end
    endtask

    task automatic test_upper();
        int w;
        issue(32'h12345317, 32'h100, w); // auipc x6,0x12345
        checks++; if (alu_sel !== 5'd20 || alu_in1 !== 32'h100 || alu_in2 !== 32'h12345000 || rd !== 5'd6) begin errors++; $display("FAIL auipc_op got sel=%0d in1=%h in2=%h rd=%0d exp 20/100/12345000/6", alu_sel, alu_in1, alu_in2, rd); end
        retire(5'd6);
        issue(32'h800003B7, 32'h200, w); // lui x7,0x80000
        checks++; if (alu_sel !== 5'd19 || alu_in1 !== 32'h0 || alu_in2 !== 32'h80000000 || rd !== 5'd7) begin errors++; $display("FAIL lui_op got sel=%0d in1=%h in2=%h rd=%0d exp 19/0/80000000/7", alu_sel, alu_in1, alu_in2, rd); end
        retire(5'd7);
    endtask

    task automatic test_back_to_back();
        int w;
        issue(32'h002081B3, 32'h0, w); // add x3,x1,x2 -> x3 pending
        instr = 32'h003183B3; in_valid = 1'b1; #1; // add x7,x3,x3
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0 got %0d exp 0", in_ready); end
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall1 got %0d exp 0", in_ready); end
        wb_valid = 1'b1; wb_rd = 5'd3; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_no_bypass got %0d exp 0", in_ready); end
        @(negedge clk);
        wb_valid = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb got %0d exp 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || alu_in1 !== 32'd11 || alu_in2 !== 32'd11 || rd !== 5'd7) begin errors++; $display("FAIL raw_op got v=%0d in1=%0d in2=%0d rd=%0d exp 1/11/11/7", out_valid, alu_in1, alu_in2, rd); end
        retire(5'd7);
    endtask

    task automatic test_set_clear();
        int w;
        issue(32'h002081B3, 32'h0, w); // x3 pending
        instr = 32'h002081B3; in_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL setclr_accept got %0d exp 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        instr = 32'h003183B3; in_valid = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL setclr_set_wins got %0d exp 0", in_ready); end
        in_valid = 1'b0;
        retire(5'd3);
        issue(32'h003183B3, 32'h0, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL setclr_release got %0d waits exp 0", w); end
        retire(5'd7);
    endtask

    task automatic test_illegal();
        int w;
        issue(32'h00208463, 32'h0, w); // beq: opcode 1100011, rd field = 8
        checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || rd_we !== 1'b0) begin errors++; $display("FAIL br_illegal got v=%0d ill=%0d we=%0d exp 1/1/0", out_valid, illegal, rd_we); end
        checks++; if (alu_sel !== 5'd0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0 || rd !== 5'd8) begin errors++; $display("FAIL br_fields got sel=%0d in1=%h in2=%h rd=%0d exp 0/0/0/8", alu_sel, alu_in1, alu_in2, rd); end
        issue(32'h008404B3, 32'h0, w); // add x9,x8,x8
        checks++; if (w !== 0) begin errors++; $display("FAIL br_no_pending got %0d waits exp 0", w); end
        retire(5'd9);
    endtask

    task automatic test_backpressure();
        int  acc = 0;
        int  acc_stall = 0;
        int  got = 0;
        logic fire_in;
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (acc < 4);
            instr = (32'(acc + 1) << 20) | (32'(11 + acc) << 7) | 32'h13; // addi x(11+acc),x0,acc+1
            #1;
            fire_in = in_valid && in_ready;
            if (cyc >= 1 && cyc < 4) begin
                checks++; if (out_valid !== 1'b1 || alu_in2 !== 32'd1 || rd !== 5'd11) begin errors++; $display("FAIL hold_stable cyc=%0d got v=%0d in2=%0d rd=%0d exp 1/1/11", cyc, out_valid, alu_in2, rd); end
            end
            if (out_valid && out_ready) begin
                checks++; if (alu_in2 !== 32'(got + 1)) begin errors++; $display("FAIL drain_order got in2=%0d exp %0d", alu_in2, got + 1); end
                got++;
            end
            @(posedge clk);
            if (fire_in) begin
                acc++;
                if (cyc < 4) acc_stall++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (acc_stall !== EXP_STALL_ACC) begin errors++; $display("FAIL stall_accepts got %0d exp %0d", acc_stall, EXP_STALL_ACC); end
        checks++; if (got !== 4) begin errors++; $display("FAIL drain_count got %0d exp 4", got); end
    endtask

    task automatic test_reset_mid_stall();
        int w;
        out_ready = 1'b0;
        issue(32'h00500A13, 32'h0, w); // addi x20,x0,5, held
        #1;
        checks++; if (out_valid !== 1'b1 || alu_in2 !== 32'd5) begin errors++; $display("FAIL held_before_rst got v=%0d in2=%0d exp 1/5", out_valid, alu_in2); end
        rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || alu_in2 !== 32'h0 || rd_we !== 1'b0) begin errors++; $display("FAIL async_rst got v=%0d in2=%h we=%0d exp 0/0/0", out_valid, alu_in2, rd_we); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        issue(32'h00C587B3, 32'h0, w); // add x15,x11,x12: pending cleared by reset
        checks++; if (w !== 0) begin errors++; $display("FAIL rst_pending_clear got %0d waits exp 0", w); end
        checks++; if (alu_sel !== 5'd0 || rd !== 5'd15) begin errors++; $display("FAIL post_rst_op got sel=%0d rd=%0d exp 0/15", alu_sel, rd); end
        retire(5'd15);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[3] = 32'd11;
        rf[5] = 32'd40;
        test_reset();
        test_op();
        test_op_imm();
        test_upper();
        test_back_to_back();
        test_set_clear();
        test_illegal();
        test_backpressure();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
